// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_e : arbiter FSM states (core owns dram in IDLE/ACK, aux owns it in GRANT)
//   wait_cnt_w  : width of the starvation counter able to hold 0..MAX_WAIT
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter used to bound how long the auxiliary master can be
// blocked by the core.
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset, clears the count
//   i_inc    : increment request (ignored once the count equals i_max)
//   i_clr    : synchronous clear, has priority over i_inc
//   i_max    : saturation value
//   o_at_max : count equals i_max
module starve_counter #(
    parameter int unsigned W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    input  logic [W-1:0] i_max,
    output logic         o_at_max
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_max = (r_count == i_max);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (default owner) and an
// auxiliary master using a req/ack handshake. The aux master gets one memory
// cycle (GRANT) when the core is idle, or is forced in after MAX_WAIT
// consecutive blocked cycles, stalling the core for that single cycle.
//   clk, reset                      : clock, async active-high reset
//   cpu_req/we/addr/wdata           : core data-memory request
//   cpu_rdata, cpu_stall            : core load data, core hold request
//   aux_req/we/addr/wdata           : auxiliary request, held until aux_ack
//   aux_ack, aux_rdata              : one-cycle completion pulse, registered read data
//   mem_we/addr/wdata, mem_rdata    : dram port (combinational read)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned       CNT_W   = wait_cnt_w(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic              w_inc;
    logic              w_clr;
    logic              w_at_max;
    logic [DATA_W-1:0] r_aux_rdata;

    starve_counter #(
        .W (CNT_W)
    ) u_wait_cnt (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .i_max    (CNT_MAX),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter only moves in IDLE: it counts blocked cycles, clears when the
    // request is withdrawn, and clears on the transition into GRANT.
    always_comb begin
        w_next = r_state;
        w_inc  = 1'b0;
        w_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (aux_req) begin
                    if (!cpu_req || w_at_max) begin
                        w_next = GRANT;
                        w_clr  = 1'b1;
                    end else begin
                        w_inc  = 1'b1;
                    end
                end else begin
                    w_clr = 1'b1;
                end
            end
            GRANT:   w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = cpu_we & cpu_req;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        if (r_state == GRANT) begin
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            cpu_stall = cpu_req;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign aux_ack   = (r_state == ACK);

    // Read data for the aux master is sampled at the end of its GRANT cycle
    // so it stays valid during ACK while the core drives the address again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aux_rdata <= '0;
        end else if (r_state == GRANT) begin
            r_aux_rdata <= mem_rdata;
        end
    end

    assign aux_rdata = r_aux_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        aux_req, aux_we;
    logic [31:0] aux_addr, aux_wdata;
    logic        aux_ack;
    logic [31:0] aux_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .aux_req   (aux_req),
        .aux_we    (aux_we),
        .aux_addr  (aux_addr),
        .aux_wdata (aux_wdata),
        .aux_ack   (aux_ack),
        .aux_rdata (aux_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Environment dram: 256 words, combinational read, write on clock edge
    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    logic [31:0] mem [0:255];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr[9:2]];

    // Reference model: schedule-based view of the protocol
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc, grant_cyc, ack_cyc, blocked;
    logic [31:0] ref_mem [0:255];
    logic [31:0] cap;
    logic        m_g, m_a, e_we;
    logic [31:0] e_addr, e_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; grant_cyc = -1; ack_cyc = -1; blocked = 0; cap = '0;
    endtask

    // Settle to the falling edge and compare all outputs with the model
    task automatic half();
        #4;
        m_g = (cyc == grant_cyc);
        m_a = (cyc == ack_cyc);
        if (m_g) begin
            e_we = aux_we; e_addr = aux_addr; e_wd = aux_wdata;
        end else begin
            e_we = cpu_we & cpu_req; e_addr = cpu_addr; e_wd = cpu_wdata;
        end
        chk("mem_we",    32'(mem_we),    32'(e_we));
        chk("mem_addr",  mem_addr,       e_addr);
        chk("mem_wdata", mem_wdata,      e_wd);
        chk("cpu_stall", 32'(cpu_stall), 32'(m_g & cpu_req));
        chk("aux_ack",   32'(aux_ack),   32'(m_a));
        chk("cpu_rdata", cpu_rdata,      ref_mem[e_addr[9:2]]);
        if (m_a) chk("aux_rdata", aux_rdata, cap);
    endtask

    // Apply the clock edge to the model and to the DUT
    task automatic fin();
        if (m_g) cap = ref_mem[aux_addr[9:2]];
        if (e_we) ref_mem[e_addr[9:2]] = e_wd;
        if (!m_g && !m_a) begin
            if (aux_req) begin
                if (!cpu_req || blocked == MAXW) begin
                    grant_cyc = cyc + 1;
                    ack_cyc   = cyc + 2;
                    blocked   = 0;
                end else if (blocked < MAXW) begin
                    blocked++;
                end
            end else begin
                blocked = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        half();
        fin();
    endtask

    initial begin
        bit g, a, hold;
        int nst, ack_at, busy_pct;

        reset = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = '0; aux_wdata = '0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_aux_ack",   32'(aux_ack),   32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_aux_rdata", aux_rdata,      32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; mem_init = 1'b0;
        cpu_req = 1'b0; aux_req = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();

        // Core idle, aux write 0xDEADBEEF to 0x40
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h40; aux_wdata = 32'hDEADBEEF;
        cycle();
        half();
        chk("t1_grant_we",   32'(mem_we), 32'd1);
        chk("t1_grant_addr", mem_addr,    32'h40);
        fin();
        aux_req = 1'b0;
        half();
        chk("t1_ack", 32'(aux_ack), 32'd1);
        fin();

        // Aux read back of 0x40
        aux_req = 1'b1; aux_we = 1'b0;
        cycle();
        cycle();
        aux_req = 1'b0;
        half();
        chk("t2_rdata", aux_rdata, 32'hDEADBEEF);
        fin();

        // Core continuously busy: forced grant after MAX_WAIT blocked cycles
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h44;
        nst = 0; ack_at = -1;
        for (int k = 0; k < 10; k++) begin
            if (cyc == ack_cyc) aux_req = 1'b0;
            half();
            if (cpu_stall) nst++;
            if (aux_ack && ack_at < 0) ack_at = k;
            fin();
        end
        chk("t3_stall_cycles", 32'(nst),    32'd1);
        chk("t3_ack_latency",  32'(ack_at), 32'(MAXW + 2));

        // Core store issued in the forced GRANT cycle completes in ACK
        cpu_addr = 32'h80; cpu_wdata = 32'h12345678;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h84; aux_wdata = 32'hCAFEF00D;
        for (int k = 0; k < 10; k++) begin
            g = (cyc == grant_cyc);
            a = (cyc == ack_cyc);
            if (a) aux_req = 1'b0;
            cpu_we = g | a;
            half();
            if (g || a) chk("t4_core_pending", mem[32], init_word(32));
            fin();
        end
        cpu_we = 1'b0;
        chk("t4_core_store", mem[32], 32'h12345678);
        chk("t4_aux_store",  mem[33], 32'hCAFEF00D);

        // Reset asserted in the middle of GRANT
        cpu_req = 1'b0;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h90; aux_wdata = 32'h0BADF00D;
        cycle();
        cpu_req = 1'b1; cpu_we = 1'b0;
        #2;
        chk("t5_in_grant", 32'(cpu_stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_stall",  32'(cpu_stall), 32'd0);
        chk("t5_rst_ack",    32'(aux_ack),   32'd0);
        chk("t5_rst_mem_we", 32'(mem_we),    32'd0);
        @(posedge clk);
        #1;
        aux_req = 1'b0; cpu_req = 1'b0;
        #2;
        chk("t5_rst_rdata", aux_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("t5_no_write", mem[36], init_word(36));

        // Aux request withdrawn while blocked must clear the wait count
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h48;
        nst = 0;
        for (int k = 0; k < 3; k++) begin
            half();
            if (cpu_stall) nst++;
            fin();
        end
        aux_req = 1'b0;
        half();
        if (cpu_stall) nst++;
        fin();
        chk("t6_no_stall_after_pulse", 32'(nst), 32'd0);
        aux_req = 1'b1;
        ack_at = -1;
        for (int k = 0; k < 10; k++) begin
            if (cyc == ack_cyc) aux_req = 1'b0;
            half();
            if (cpu_stall) nst++;
            if (aux_ack && ack_at < 0) ack_at = k;
            fin();
        end
        chk("t6_stall_cycles", 32'(nst),    32'd1);
        chk("t6_ack_latency",  32'(ack_at), 32'(MAXW + 2));

        // Random traffic from both masters
        hold = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            g = (cyc == grant_cyc);
            a = (cyc == ack_cyc);
            busy_pct = ((k / 64) % 2 == 1) ? 90 : 35;
            if (!hold) begin
                cpu_req   = ($urandom_range(99) < busy_pct);
                cpu_we    = 1'($urandom_range(1));
                cpu_addr  = {22'b0, 8'($urandom), 2'b0};
                cpu_wdata = $urandom;
            end
            if (a) begin
                aux_req = 1'b0;
            end else if (!g) begin
                if (aux_req) begin
                    if ($urandom_range(15) == 0) aux_req = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    aux_req   = 1'b1;
                    aux_we    = 1'($urandom_range(1));
                    aux_addr  = {22'b0, 8'($urandom), 2'b0};
                    aux_wdata = $urandom;
                end
            end
            half();
            hold = m_g & cpu_req;
            fin();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
